mm_dot_engine: RTL and testbench

Sequencer and multiply-accumulate stage that sits directly downstream of the image memory and the weight-matrix memory in the matrix-multiply datapath. On a start pulse it walks LENGTH consecutive addresses in both memories and accumulates signed fixed-point products. It then returns one saturated 32-bit dot-product result with a single-cycle done pulse. Both memories are combinational-read: data is valid in the same cycle the address is driven.

---
 rtl/mm_dot_engine.sv | 101 ++++++++++
 tb/tb_mm_dot_engine.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mm_dot_engine.sv
// Dot-product sequencer: walks two combinational-read memories in lockstep and
// accumulates signed Q-format products into a saturated, arithmetically-shifted result.
module mm_dot_engine #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 16,
  parameter int FRAC_BITS = 16,
  parameter int ACC_W     = 72
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     start,
  input  logic        [ADDR_W-1:0] img_base,
  input  logic        [ADDR_W-1:0] wgt_base,
  input  logic        [ADDR_W-1:0] length,
  output logic        [ADDR_W-1:0] img_addr,
  input  logic signed [DATA_W-1:0] img_data,
  output logic        [ADDR_W-1:0] wgt_addr,
  input  logic signed [DATA_W-1:0] wgt_data,
  output logic                     busy,
  output logic                     done,
  output logic signed [DATA_W-1:0] result
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic        [1:0]          state;
  logic        [ADDR_W-1:0]   count;
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    acc_next;
  logic signed [ACC_W-1:0]    shifted;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [DATA_W-1:0]   sat_val;
  logic                       last;

  // Operands are sign-extended to full width so the low 2*DATA_W bits of the
  // unsigned product equal the signed product.
  always_comb begin
    prod     = {{DATA_W{img_data[DATA_W-1]}}, img_data} *
               {{DATA_W{wgt_data[DATA_W-1]}}, wgt_data};
    acc_next = acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    shifted  = acc_next >>> FRAC_BITS;
    if ((&shifted[ACC_W-1:DATA_W-1]) || !(|shifted[ACC_W-1:DATA_W-1]))
      sat_val = shifted[DATA_W-1:0];
    else if (shifted[ACC_W-1])
      sat_val = {1'b1, {(DATA_W-1){1'b0}}};
    else
      sat_val = {1'b0, {(DATA_W-1){1'b1}}};
    last = (count == ADDR_W'(1));
  end

  always_comb begin
    busy = (state == S_RUN) || (state == S_DONE);
    done = (state == S_DONE);
  end

  // The final product is folded in on the last RUN edge so result is already
  // registered when DONE is entered.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      img_addr <= '0;
      wgt_addr <= '0;
      count    <= '0;
      acc      <= '0;
      result   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            acc <= '0;
            if (length != '0) begin
              img_addr <= img_base;
              wgt_addr <= wgt_base;
              count    <= length;
              state    <= S_RUN;
            end else begin
              result <= '0;
              state  <= S_DONE;
            end
          end
        end
        S_RUN: begin
          acc   <= acc_next;
          count <= count - ADDR_W'(1);
          if (last) begin
            result <= sat_val;
            state  <= S_DONE;
          end else begin
            img_addr <= img_addr + ADDR_W'(1);
            wgt_addr <= wgt_addr + ADDR_W'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_dot_engine.sv
// Self-checking bench for mm_dot_engine: table-driven operations with a result/address
// scoreboard, plus hand-written busy-start and mid-run reset sequences.
module tb_mm_dot_engine;

  logic               clk = 1'b0;
  logic               resetn = 1'b0;
  logic               start = 1'b0;
  logic        [15:0] img_base = '0;
  logic        [15:0] wgt_base = '0;
  logic        [15:0] length = '0;
  logic        [15:0] img_addr;
  logic        [15:0] wgt_addr;
  logic signed [31:0] img_data;
  logic signed [31:0] wgt_data;
  logic               busy;
  logic               done;
  logic signed [31:0] result;

  logic [31:0] img_mem [65536];
  logic [31:0] wgt_mem [65536];

  assign img_data = img_mem[img_addr];
  assign wgt_data = wgt_mem[wgt_addr];

  mm_dot_engine #(.DATA_W(32), .ADDR_W(16), .FRAC_BITS(16), .ACC_W(72)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .img_base(img_base), .wgt_base(wgt_base), .length(length),
    .img_addr(img_addr), .img_data(img_data),
    .wgt_addr(wgt_addr), .wgt_data(wgt_data),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [31:0] res_q [$];
  logic [31:0] addr_q [$];
  logic        track = 1'b1;

  int unsigned accept_cyc;
  logic [15:0] last_img, last_wgt;

  typedef struct {
    string       name;
    logic [15:0] ib;
    logic [15:0] wb;
    logic [15:0] len;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_dot(input logic [15:0] ib, input logic [15:0] wb,
                                             input logic [15:0] len);
    logic signed [71:0] acc;
    logic signed [71:0] sh;
    logic signed [63:0] p;
    logic [15:0] ia, wa;
    acc = '0;
    for (int unsigned i = 0; i < len; i++) begin
      ia = ib + 16'(i);
      wa = wb + 16'(i);
      p = $signed(img_mem[ia]) * $signed(wgt_mem[wa]);
      acc = acc + p;
    end
    sh = acc >>> 16;
    if (sh > 72'sd2147483647) return 32'h7FFFFFFF;
    if (sh < -72'sd2147483648) return 32'h80000000;
    return sh[31:0];
  endfunction

  // Scoreboard: address pairs during RUN cycles, result on each done pulse.
  always @(negedge clk) begin
    if (resetn) begin
      if (busy && !done && track) begin
        if (addr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL addr_extra: got %h expected none", {img_addr, wgt_addr});
        end else begin
          check("addr_seq", {img_addr, wgt_addr}, addr_q.pop_front());
        end
      end
      if (done) begin
        if (res_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got result %h expected no done", result);
        end else begin
          check("result", result, res_q.pop_front());
        end
      end
    end
  end

  task automatic wait_idle();
    int unsigned guard = 0;
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (busy) begin
      checks++; errors++;
      $display("FAIL idle_timeout: got busy=1 expected busy=0");
    end
  endtask

  task automatic start_op(input logic [15:0] ib, input logic [15:0] wb, input logic [15:0] len,
                          input logic [31:0] exp, input bit expect_out);
    wait_idle();
    @(negedge clk);
    if (expect_out) begin
      for (int unsigned i = 0; i < len; i++)
        addr_q.push_back({ib + 16'(i), wb + 16'(i)});
      res_q.push_back(exp);
    end
    last_img = ib + len - 16'd1;
    last_wgt = wb + len - 16'd1;
    start = 1'b1; img_base = ib; wgt_base = wb; length = len;
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    start = 1'b0;
    img_base = $urandom; wgt_base = $urandom; length = $urandom;
  endtask

  task automatic finish_op(input logic [15:0] len, input logic [31:0] exp, input string name);
    int unsigned guard = 0;
    while (!done && guard < 32'(len) + 10) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no done expected done after %0d cycles", name, len + 1);
    end else begin
      check({name, "_latency"}, cyc - accept_cyc, 32'(len));
      @(posedge clk);
      #1;
      check({name, "_pulse"}, {30'b0, busy, done}, 32'd0);
      check({name, "_hold"}, result, exp);
      if (len != 0)
        check({name, "_last_addr"}, {img_addr, wgt_addr}, {last_img, last_wgt});
    end
  endtask

  initial begin
    for (int unsigned a = 0; a < 65536; a++) begin
      img_mem[a] = '0;
      wgt_mem[a] = '0;
    end
    for (int unsigned a = 0; a < 4; a++) img_mem[a] = 32'h00010000;
    wgt_mem[100] = 32'h00020000; wgt_mem[101] = 32'h00008000;
    wgt_mem[102] = 32'hFFFF0000; wgt_mem[103] = 32'h00030000;
    img_mem[200] = 32'h7FFF0000; img_mem[201] = 32'h7FFF0000;
    wgt_mem[300] = 32'h7FFF0000; wgt_mem[301] = 32'h7FFF0000;
    wgt_mem[400] = 32'h80000000; wgt_mem[401] = 32'h80000000;
    img_mem[16'hFFFE] = 32'h00010000; img_mem[16'hFFFF] = 32'h00010000;
    wgt_mem[500] = 32'h00010000; wgt_mem[501] = 32'h00020000; wgt_mem[502] = 32'h00030000;
    img_mem[3000] = 32'h00000001; wgt_mem[3000] = 32'hFFFFFFFF;
    img_mem[600] = 32'h00010000; img_mem[601] = 32'h00010000;
    wgt_mem[700] = 32'h00010000; wgt_mem[701] = 32'h00010000;
    for (int unsigned i = 0; i < 8; i++) begin
      img_mem[1000 + i] = $urandom_range(0, 32'h3FFFF) - 32'h1FFFF;
      wgt_mem[2000 + i] = $urandom_range(0, 32'h3FFFF) - 32'h1FFFF;
    end

    vecs[0] = '{"basic",   16'd0,     16'd100,  16'd4, 32'h00048000};
    vecs[1] = '{"sat_pos", 16'd200,   16'd300,  16'd2, 32'h7FFFFFFF};
    vecs[2] = '{"sat_neg", 16'd200,   16'd400,  16'd2, 32'h80000000};
    vecs[3] = '{"len0",    16'd0,     16'd0,    16'd0, 32'h00000000};
    vecs[4] = '{"wrap",    16'hFFFE,  16'd500,  16'd3, 32'h00060000};
    vecs[5] = '{"trunc",   16'd3000,  16'd3000, 16'd1, 32'hFFFFFFFF};
    vecs[6] = '{"rand8",   16'd1000,  16'd2000, 16'd8, model_dot(16'd1000, 16'd2000, 16'd8)};
    vecs[7] = '{"rand5",   16'd1003,  16'd2001, 16'd5, model_dot(16'd1003, 16'd2001, 16'd5)};

    // Reset held, then idle with start low.
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("idle_flags", {30'b0, busy, done}, 32'd0);
      check("idle_result", result, 32'd0);
      check("idle_addr", {img_addr, wgt_addr}, 32'd0);
    end

    foreach (vecs[k]) begin
      start_op(vecs[k].ib, vecs[k].wb, vecs[k].len, vecs[k].exp, 1'b1);
      finish_op(vecs[k].len, vecs[k].exp, vecs[k].name);
    end

    // Second start during RUN must be ignored.
    start_op(16'd0, 16'd100, 16'd4, 32'h00048000, 1'b1);
    @(negedge clk);
    start = 1'b1; img_base = 16'h0050; wgt_base = 16'h0060; length = 16'd1;
    @(negedge clk);
    start = 1'b0;
    finish_op(16'd4, 32'h00048000, "busy_start");
    repeat (6) @(negedge clk);
    check("busy_start_idle", {30'b0, busy, done}, 32'd0);

    // Asynchronous reset in the second RUN cycle aborts without a done.
    track = 1'b0;
    start_op(16'd0, 16'd100, 16'd4, 32'h0, 1'b0);
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("abort_flags", {30'b0, busy, done}, 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_addr", {img_addr, wgt_addr}, 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    track = 1'b1;
    start_op(16'd600, 16'd700, 16'd2, 32'h00020000, 1'b1);
    finish_op(16'd2, 32'h00020000, "post_reset");

    repeat (3) @(negedge clk);
    check("queues_drained", 32'(res_q.size() + addr_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
